// File: rtl/ocra1_dac_iface.sv
// OCRA1 gradient DAC serialiser: buffers one 24-bit word per channel (X, Y, Z, Z2) and,
// on trigger, shifts all four out in parallel on a shared SCLK/SYNCn, then pulses LDACn.
module ocra1_dac_iface (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    input  logic [5:0]  spi_clk_div_i,
    output logic        oc1_clk_o,
    output logic        oc1_syncn_o,
    output logic        oc1_ldacn_o,
    output logic        oc1_sdox_o,
    output logic        oc1_sdoy_o,
    output logic        oc1_sdoz_o,
    output logic        oc1_sdoz2_o,
    output logic        busy_o,
    output logic        data_lost_o
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_LDAC} state_t;

    state_t      state_q, state_d;
    logic [23:0] buf_q [4];
    logic [23:0] buf_d [4];
    logic [23:0] sh_q  [4];
    logic [23:0] sh_d  [4];
    logic [3:0]  pend_q, pend_d;
    logic        lost_q, lost_d;
    logic        trig_q, trig_d;
    logic [5:0]  div_q, div_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [2:0]  seq_q, seq_d;
    logic        sclk_q, sclk_d;
    logic        syncn_q, syncn_d;
    logic        ldacn_q, ldacn_d;
    logic [3:0]  sdo_q, sdo_d;

    logic [1:0]  wr_ch;
    logic        start;
    logic [6:0]  half_p;
    logic        unused_hdr;

    assign wr_ch      = data_i[26:25];
    assign unused_hdr = ^data_i[31:27];
    assign start      = (state_q == S_IDLE) && trig_q;
    // SCLK stays high for ceil(P/2) cycles of each P = D+1 cycle bit period
    assign half_p     = ({1'b0, div_q} + 7'd2) >> 1;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        sh_d    = sh_q;
        pend_d  = pend_q;
        lost_d  = lost_q;
        trig_d  = trig_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        seq_d   = seq_q;
        sclk_d  = sclk_q;
        syncn_d = syncn_q;
        ldacn_d = ldacn_q;
        sdo_d   = sdo_q;

        // Pending flags are cleared by the snapshot before a same-edge write re-arms them
        if (start) pend_d = '0;
        if (valid_i) begin
            buf_d[wr_ch] = data_i[23:0];
            if (pend_d[wr_ch]) lost_d = 1'b1;
            pend_d[wr_ch] = 1'b1;
        end
        trig_d = (trig_q & ~start) | (valid_i & data_i[24]);

        case (state_q)
            S_IDLE: begin
                if (trig_q) begin
                    state_d = S_SHIFT;
                    sh_d    = buf_q;
                    div_d   = (spi_clk_div_i == 6'd0) ? 6'd1 : spi_clk_div_i;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b1;
                    syncn_d = 1'b0;
                    for (int i = 0; i < 4; i++) sdo_d[i] = buf_q[i][23];
                end
            end
            S_SHIFT: begin
                if (cnt_q == div_q) begin
                    cnt_d = '0;
                    if (bit_q == 5'd23) begin
                        state_d = S_GAP;
                        seq_d   = '0;
                        sclk_d  = 1'b0;
                        syncn_d = 1'b1;
                        sdo_d   = '0;
                    end else begin
                        bit_d  = bit_q + 5'd1;
                        sclk_d = 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            sh_d[i]  = {sh_q[i][22:0], 1'b0};
                            sdo_d[i] = sh_q[i][22];
                        end
                    end
                end else begin
                    cnt_d  = cnt_q + 6'd1;
                    sclk_d = ({1'b0, cnt_q} + 7'd1) < half_p;
                end
            end
            S_GAP: begin
                if (seq_q == 3'd2) begin
                    state_d = S_LDAC;
                    seq_d   = '0;
                    ldacn_d = 1'b0;
                end else begin
                    seq_d = seq_q + 3'd1;
                end
            end
            S_LDAC: begin
                if (seq_q == 3'd3) begin
                    state_d = S_IDLE;
                    ldacn_d = 1'b1;
                end else begin
                    seq_d = seq_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            buf_q   <= '{default: '0};
            sh_q    <= '{default: '0};
            pend_q  <= '0;
            lost_q  <= 1'b0;
            trig_q  <= 1'b0;
            div_q   <= 6'd1;
            cnt_q   <= '0;
            bit_q   <= '0;
            seq_q   <= '0;
            sclk_q  <= 1'b0;
            syncn_q <= 1'b1;
            ldacn_q <= 1'b1;
            sdo_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            sh_q    <= sh_d;
            pend_q  <= pend_d;
            lost_q  <= lost_d;
            trig_q  <= trig_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            seq_q   <= seq_d;
            sclk_q  <= sclk_d;
            syncn_q <= syncn_d;
            ldacn_q <= ldacn_d;
            sdo_q   <= sdo_d;
        end
    end

    assign oc1_clk_o   = sclk_q;
    assign oc1_syncn_o = syncn_q;
    assign oc1_ldacn_o = ldacn_q;
    assign oc1_sdox_o  = sdo_q[0];
    assign oc1_sdoy_o  = sdo_q[1];
    assign oc1_sdoz_o  = sdo_q[2];
    assign oc1_sdoz2_o = sdo_q[3];
    assign busy_o      = (state_q != S_IDLE);
    assign data_lost_o = lost_q;

endmodule

// File: tb/tb_ocra1_dac_iface.sv
// Bench for ocra1_dac_iface: a 4-lane AD5781 model decodes the pins; a scoreboard of expected
// frames (from a channel-buffer reference model) is checked whenever a frame completes.
module tb_ocra1_dac_iface;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic [5:0]  div_i = 6'd32;
    logic        sclk, syncn, ldacn, sdox, sdoy, sdoz, sdoz2, busy, lost;

    always #5 clk = ~clk;

    ocra1_dac_iface dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .spi_clk_div_i (div_i),
        .oc1_clk_o     (sclk),
        .oc1_syncn_o   (syncn),
        .oc1_ldacn_o   (ldacn),
        .oc1_sdox_o    (sdox),
        .oc1_sdoy_o    (sdoy),
        .oc1_sdoz_o    (sdoz),
        .oc1_sdoz2_o   (sdoz2),
        .busy_o        (busy),
        .data_lost_o   (lost)
    );

    typedef struct packed {
        logic [95:0] w;   // four 24-bit words, lane 0 = X in the low bits
        logic [71:0] vb;  // DAC outputs before the LDAC of this frame
        logic [71:0] va;  // DAC outputs after it
        logic [6:0]  p;   // bit period in clk cycles
    } frame_t;

    frame_t      exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          frames_done = 0;
    int          frames_target = 0;
    logic [23:0] ref_buf [4];
    logic [3:0]  ref_pend;
    logic        ref_lost;
    logic [17:0] ref_vout [4];
    logic [17:0] dac_vout [4];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 4; i++) ref_buf[i] = '0;
        ref_pend = '0;
        ref_lost = 1'b0;
    endtask

    // One accepted word; a trigger snapshots the reference buffers into an expected frame
    task automatic wr(input logic [1:0] ch, input logic [23:0] w, input logic trig);
        frame_t f;
        @(negedge clk);
        data_i  = {5'($urandom_range(0, 31)), ch, trig, w};
        valid_i = 1'b1;
        if (ref_pend[ch]) ref_lost = 1'b1;
        ref_pend[ch] = 1'b1;
        ref_buf[ch]  = w;
        if (trig) begin
            for (int i = 0; i < 4; i++) begin
                f.w[i*24 +: 24] = ref_buf[i];
                f.vb[i*18 +: 18] = ref_vout[i];
                if (ref_buf[i][23:20] == 4'h1) ref_vout[i] = ref_buf[i][19:2];
                f.va[i*18 +: 18] = ref_vout[i];
            end
            f.p = ((div_i == 6'd0) ? 7'd1 : {1'b0, div_i}) + 7'd1;
            ref_pend = '0;
            exp_q.push_back(f);
            frames_target++;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frames(input int budget);
        int c = 0;
        while (frames_done < frames_target && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("frame_wait_timeout", frames_done, frames_target);
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("reset_lines", {syncn, ldacn, busy, sclk, sdoz2, sdoz, sdoy, sdox, lost}, 9'b110000000);
        @(negedge clk);
        rst = 1'b0;
        if (exp_q.size() > 0) begin
            for (int i = 0; i < 4; i++) ref_vout[i] = exp_q[0].vb[i*18 +: 18];
            exp_q.delete();
            frames_target = frames_done;
        end
        ref_reset();
    endtask

    // Monitor: AD5781 lane model plus frame timing checks against the expected queue
    initial begin
        int          phase = 0;
        int          low_cnt = 0;
        int          nbits = 0;
        int          gap = 0;
        int          lc = 0;
        logic        prev_sclk = 1'b0;
        logic [23:0] sr [4];
        logic [23:0] dac_word [4];
        logic [71:0] va = '0;
        frame_t      f;
        for (int i = 0; i < 4; i++) begin
            dac_vout[i] = '0;
            sr[i] = '0;
            dac_word[i] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                phase = 0;
            end else begin
                case (phase)
                    0: if (!syncn) begin
                        phase = 1;
                        low_cnt = 1;
                        nbits = 0;
                        for (int i = 0; i < 4; i++) sr[i] = '0;
                        prev_sclk = sclk;
                    end
                    1: if (!syncn) begin
                        low_cnt++;
                        if (prev_sclk && !sclk) begin
                            nbits++;
                            sr[0] = {sr[0][22:0], sdox};
                            sr[1] = {sr[1][22:0], sdoy};
                            sr[2] = {sr[2][22:0], sdoz};
                            sr[3] = {sr[3][22:0], sdoz2};
                        end
                        prev_sclk = sclk;
                        if (low_cnt > 3000) begin
                            check("syncn_stuck_low", low_cnt, 0);
                            phase = 0;
                        end
                    end else if (exp_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                        phase = 0;
                    end else begin
                        f = exp_q.pop_front();
                        check("frame_bits", nbits, 24);
                        check("syncn_low_cycles", low_cnt, 24 * int'(f.p));
                        check("frame_words", {sr[3], sr[2], sr[1], sr[0]}, f.w);
                        check("idle_lines", {sclk, sdoz2, sdoz, sdoy, sdox}, 5'b0);
                        check("vout_before", {dac_vout[3], dac_vout[2], dac_vout[1], dac_vout[0]}, f.vb);
                        dac_word = sr;
                        va = f.va;
                        gap = 1;
                        phase = 2;
                    end
                    2: if (ldacn) begin
                        gap++;
                        if (gap > 10) begin
                            check("ldacn_missing", gap, 3);
                            phase = 0;
                        end
                    end else begin
                        check("syncn_to_ldacn", gap, 3);
                        for (int i = 0; i < 4; i++)
                            if (dac_word[i][23:20] == 4'h1) dac_vout[i] = dac_word[i][19:2];
                        check("vout_after", {dac_vout[3], dac_vout[2], dac_vout[1], dac_vout[0]}, va);
                        check("busy_in_ldac", busy, 1'b1);
                        lc = 1;
                        phase = 3;
                    end
                    3: if (!ldacn) begin
                        lc++;
                        if (lc > 10) begin
                            check("ldacn_stuck_low", lc, 4);
                            phase = 0;
                        end
                    end else begin
                        check("ldacn_low_cycles", lc, 4);
                        check("busy_after_ldac", busy, 1'b0);
                        frames_done++;
                        phase = 0;
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int c;
        logic [1:0] ch;
        int nw;
        ref_reset();
        for (int i = 0; i < 4; i++) ref_vout[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {sclk, syncn, ldacn, sdoz2, sdoz, sdoy, sdox, busy, lost}, 9'b011000000);
        rst = 1'b0;

        // Init frame: non-load header, outputs stay at zero
        div_i = 6'd32;
        wr(0, 24'h200002, 0);
        wr(1, 24'h200002, 0);
        wr(2, 24'h200002, 0);
        wr(3, 24'h200002, 1);
        @(posedge clk);
        #2;
        check("start_wait_cycle", {syncn, busy}, 2'b10);
        valid_i = 1'b0;
        @(posedge clk);
        #2;
        check("start_cycle", {syncn, busy}, 2'b01);
        wait_frames(1200);
        check("lost_after_init", lost, ref_lost);

        // Voltage load 1,2,3,4 with trigger-to-LDAC latency at D=32
        wr(0, {4'h1, 18'd1, 2'b0}, 0);
        wr(1, {4'h1, 18'd2, 2'b0}, 0);
        wr(2, {4'h1, 18'd3, 2'b0}, 0);
        wr(3, {4'h1, 18'd4, 2'b0}, 1);
        c = -1;
        do begin
            @(posedge clk);
            #2;
            valid_i = 1'b0;
            c++;
        end while (ldacn && c < 2000);
        check("trigger_to_ldacn", c, 24 * 33 + 4);
        wait_frames(200);

        wr(0, {4'h1, 18'd5, 2'b0}, 0);
        wr(1, {4'h1, 18'd6, 2'b0}, 0);
        wr(2, {4'h1, 18'd7, 2'b0}, 0);
        wr(3, {4'h1, 18'd8, 2'b0}, 1);
        idle(1);
        wait_frames(1200);

        // div=1: three triggers ~50 cycles apart force the one-deep queue
        div_i = 6'd1;
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 4; i++) begin
                logic [17:0] v;
                v = (g == 2) ? -18'(i + 1) : 18'(10 * (i + 1) + g);
                wr(2'(i), {4'h1, v, 2'b0}, i == 3);
            end
            idle(46);
        end
        wait_frames(400);
        check("queued_final_vout", {dac_vout[3], dac_vout[2], dac_vout[1], dac_vout[0]},
              {18'h3FFFC, 18'h3FFFD, 18'h3FFFE, 18'h3FFFF});
        check("queued_lost", lost, 1'b0);

        // Data-loss detection, clear on reset, then loss within a triggered frame
        div_i = 6'd4;
        repeat (4) wr(0, 24'd1234, 0);
        idle(2);
        check("lost_repeat_writes", lost, ref_lost);
        do_reset();
        wr(0, 24'd1234, 0);
        wr(0, 24'd5678, 1);
        idle(1);
        wait_frames(400);
        check("lost_after_overwrite", lost, ref_lost);

        // Reset in the middle of a frame aborts it without LDAC
        div_i = 6'd8;
        wr(0, {4'h1, 18'd100, 2'b0}, 0);
        wr(3, {4'h1, 18'd200, 2'b0}, 1);
        idle(30);
        do_reset();
        idle(300);
        check("abort_vout", {dac_vout[3], dac_vout[2], dac_vout[1], dac_vout[0]},
              {ref_vout[3], ref_vout[2], ref_vout[1], ref_vout[0]});
        check("abort_idle", {syncn, ldacn, busy}, 3'b110);

        // Randomized frames; divider changed mid-frame must not affect the running transfer
        for (int r = 0; r < 8; r++) begin
            div_i = 6'($urandom_range(0, 6));
            nw = $urandom_range(1, 6);
            for (int k = 0; k < nw; k++) begin
                logic [23:0] w;
                ch = 2'($urandom_range(0, 3));
                w = 24'($urandom);
                if ($urandom_range(0, 1) == 1) w[23:20] = 4'h1;
                wr(ch, w, k == nw - 1);
            end
            idle(3);
            div_i = 6'($urandom_range(0, 63));
            wait_frames(2000);
            check("random_lost", lost, ref_lost);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
